// File: rtl/cas_player.sv
// cas_player: tape-side FSK transmitter for the cassette input.
// Serialises bytes from a tape buffer reader into the square-wave bit stream
// sampled on casdout. Bits go out LSB first. A '1' is one full cycle of
// HALF_1-cycle phases, and a '0' is one full cycle of HALF_0-cycle phases.
// Relay-gated: a low motor input freezes playback in place.
// Optional feature: define CAS_PLAYER_SPINUP_EN to insert a SPINUP_CYCLES
// motor spin-up delay between play/motor and the first byte fetch.
// Without that macro, IDLE goes straight to LOAD.
module cas_player #(
  parameter int HALF_1        = 11932,
  parameter int HALF_0        = 23863,
  parameter int SPINUP_CYCLES = 28636000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        motor,
  input  logic        play,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        eot,
  output logic        casdout,
  output logic        busy,
  output logic        done,
  output logic [23:0] byte_count
);

  localparam int HALF_MAX = (HALF_0 > HALF_1) ? HALF_0 : HALF_1;
  localparam int HW       = $clog2(HALF_MAX + 1);
  localparam logic [HW-1:0] H1_LAST  = HW'(HALF_1 - 1);
  localparam logic [HW-1:0] H0_LAST  = HW'(HALF_0 - 1);
  localparam logic [HW-1:0] HALF_ONE = HW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPINUP = 3'd1,
    S_LOAD   = 3'd2,
    S_HIGH   = 3'd3,
    S_LOW    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        state_r, state_s;
  logic [HW-1:0] half_cnt_r, half_cnt_s;
  logic [2:0]    bit_idx_r, bit_idx_s;
  logic [7:0]    byte_r, byte_s;
  logic [23:0]   byte_count_r;
  logic          casdout_r, busy_r, done_r;
  logic          byte_ready_s, accept_s;

`ifdef CAS_PLAYER_SPINUP_EN
  localparam int SW = $clog2(SPINUP_CYCLES + 1);
  localparam logic [SW-1:0] SPIN_LAST = SW'(SPINUP_CYCLES - 1);
  localparam logic [SW-1:0] SPIN_ONE  = SW'(1);
  logic [SW-1:0] spin_cnt_r, spin_cnt_s;
`endif

  // Last value of the half-period down-counter for a bit of the given value.
  function automatic logic [HW-1:0] half_last(input logic bit_val);
    return bit_val ? H1_LAST : H0_LAST;
  endfunction

  // The handshake has to reflect this cycle's motor and play levels.
  // Otherwise a byte could be taken while the deck is frozen or stopping.
  // For that reason byte_ready is decoded from the state register rather than delayed a cycle.
  assign byte_ready_s = (state_r == S_LOAD) && motor && play;
  assign accept_s     = byte_ready_s && byte_valid;

  assign byte_ready = byte_ready_s;
  assign casdout    = casdout_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign byte_count = byte_count_r;

  // Next-state, bit sequencing and half-period timing; motor low holds everything.
  always_comb begin
    state_s    = state_r;
    half_cnt_s = half_cnt_r;
    bit_idx_s  = bit_idx_r;
    byte_s     = byte_r;
`ifdef CAS_PLAYER_SPINUP_EN
    spin_cnt_s = spin_cnt_r;
`endif
    if (!play) begin
      state_s    = S_IDLE;
      half_cnt_s = {HW{1'b0}};
      bit_idx_s  = 3'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (motor) begin
`ifdef CAS_PLAYER_SPINUP_EN
            state_s    = S_SPINUP;
            spin_cnt_s = SPIN_LAST;
`else
            state_s    = S_LOAD;
`endif
          end else begin
            state_s = S_IDLE;
          end
        end
        S_SPINUP: begin
          if (!motor) begin
            state_s = S_IDLE;
`ifdef CAS_PLAYER_SPINUP_EN
          end else if (spin_cnt_r == {SW{1'b0}}) begin
            state_s = S_LOAD;
          end else begin
            spin_cnt_s = spin_cnt_r - SPIN_ONE;
          end
`else
          end else begin
            state_s = S_LOAD;
          end
`endif
        end
        S_LOAD: begin
          // A byte presented together with eot still goes out first.
          if (accept_s) begin
            state_s    = S_HIGH;
            byte_s     = byte_data;
            bit_idx_s  = 3'd0;
            half_cnt_s = half_last(byte_data[0]);
          end else if (motor && eot) begin
            state_s = S_DONE;
          end else begin
            state_s = S_LOAD;
          end
        end
        S_HIGH: begin
          if (!motor) begin
            state_s = S_HIGH;
          end else if (half_cnt_r == {HW{1'b0}}) begin
            state_s    = S_LOW;
            half_cnt_s = half_last(byte_r[bit_idx_r]);
          end else begin
            half_cnt_s = half_cnt_r - HALF_ONE;
          end
        end
        S_LOW: begin
          if (!motor) begin
            state_s = S_LOW;
          end else if (half_cnt_r == {HW{1'b0}}) begin
            if (bit_idx_r == 3'd7) begin
              state_s = S_LOAD;
            end else begin
              state_s    = S_HIGH;
              bit_idx_s  = bit_idx_r + 3'd1;
              half_cnt_s = half_last(byte_r[bit_idx_s]);
            end
          end else begin
            half_cnt_s = half_cnt_r - HALF_ONE;
          end
        end
        S_DONE: begin
          state_s = S_DONE;
        end
        default: begin
          state_s    = S_IDLE;
          half_cnt_s = {HW{1'b0}};
          bit_idx_s  = 3'd0;
        end
      endcase
    end
  end

  // State/datapath registers; status outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      half_cnt_r   <= {HW{1'b0}};
      bit_idx_r    <= 3'd0;
      byte_r       <= 8'd0;
      byte_count_r <= 24'd0;
      casdout_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
`ifdef CAS_PLAYER_SPINUP_EN
      spin_cnt_r   <= {SW{1'b0}};
`endif
    end else begin
      state_r    <= state_s;
      half_cnt_r <= half_cnt_s;
      bit_idx_r  <= bit_idx_s;
      byte_r     <= byte_s;
      casdout_r  <= (state_s == S_HIGH);
      busy_r     <= (state_s != S_IDLE) && (state_s != S_DONE);
      done_r     <= (state_s == S_DONE);
`ifdef CAS_PLAYER_SPINUP_EN
      spin_cnt_r <= spin_cnt_s;
`endif
      if (accept_s) begin
        byte_count_r <= byte_count_r + 24'd1;
      end else begin
        byte_count_r <= byte_count_r;
      end
    end
  end

endmodule

// File: tb/tb_cas_player.sv
// tb_cas_player: randomized scoreboard bench for cas_player.
// Each issued byte becomes a list of expected phase lengths.
// A '1' bit contributes H1 high and H1 low cycles; a '0' bit contributes H0 and H0.
// The low phase of bit 7 gets one extra cycle for the following fetch.
// The monitor measures every casdout run by counting only the cycles in which the motor is running.
// It pops and compares one expectation per run.
module tb_cas_player;
  localparam int H1   = 4;
  localparam int H0   = 8;
  localparam int SPIN = 16;
`ifdef CAS_PLAYER_SPINUP_EN
  localparam int START_LAT = SPIN + 2;
`else
  localparam int START_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset, motor, play, byte_valid, byte_ready, eot;
  logic        casdout, busy, done;
  logic [7:0]  byte_data;
  logic [23:0] byte_count;

  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  logic [7:0] src_q[$];
  bit   mon_en = 1'b0;
  bit   rnd_motor = 1'b0;
  int   bc_model = 0;

  cas_player #(.HALF_1(H1), .HALF_0(H0), .SPINUP_CYCLES(SPIN)) dut (
    .clk(clk), .reset(reset), .motor(motor), .play(play),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .eot(eot), .casdout(casdout), .busy(busy), .done(done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired waiting on DUT", name);
  endtask

  // Reference model: phase lengths of one byte, LSB first.
  task automatic push_byte_expect(input logic [7:0] b);
    for (int j = 0; j < 8; j++) begin
      int h;
      h = b[j] ? H1 : H0;
      exp_q.push_back(h);
      exp_q.push_back((j == 7) ? h + 1 : h);
    end
  endtask

  task automatic pop_chk(input string name, input int act);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected run of %0d cycles, nothing expected", name, act);
    end else begin
      chk(name, act, exp_q.pop_front());
    end
  endtask

  // Monitor: measures run lengths of casdout in motor-running cycles.
  initial begin
    int  hi_act, lo_act;
    bit  in_hi, in_lo;
    hi_act = 0; lo_act = 0; in_hi = 1'b0; in_lo = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        hi_act = 0; lo_act = 0; in_hi = 1'b0; in_lo = 1'b0;
      end else if (casdout) begin
        if (in_lo) begin
          pop_chk("low_phase", lo_act);
          in_lo = 1'b0;
        end
        if (!in_hi) begin
          in_hi = 1'b1;
          hi_act = 0;
        end
        if (motor) hi_act++;
      end else begin
        if (in_hi) begin
          pop_chk("high_phase", hi_act);
          in_hi = 1'b0;
          in_lo = 1'b1;
          lo_act = 0;
        end
        if (in_lo) begin
          if (done) begin
            pop_chk("low_phase", lo_act);
            in_lo = 1'b0;
          end else if (motor) begin
            lo_act++;
          end
        end
      end
    end
  end

  // Present the first queued byte before play is raised.
  task automatic prime();
    @(posedge clk); #1;
    byte_data  = src_q[0];
    byte_valid = 1'b1;
    eot        = 1'b0;
  endtask

  // Byte source: feeds src_q, then signals eot and waits for done.
  task automatic feed();
    int n, budget;
    bit ok;
    n = src_q.size();
    foreach (src_q[i]) push_byte_expect(src_q[i]);
    byte_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      byte_data = src_q[i];
      eot = (i == n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      ok = 1'b0;
      for (budget = 0; budget < 4000; budget++) begin
        @(negedge clk);
        if (byte_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        timeout("accept");
        return;
      end
      @(posedge clk); #1;
      bc_model++;
    end
    byte_valid = 1'b0;
    eot = 1'b1;
    ok = 1'b0;
    for (budget = 0; budget < 4000; budget++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("done");
  endtask

  // Posedges from now until casdout is first seen high (-1 on timeout).
  task automatic measure_rise(output int lat);
    lat = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (casdout) return;
    end
    lat = -1;
  endtask

  task automatic stop_play();
    @(posedge clk); #1;
    play = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("stop_done", done, 1'b0);
    chk("stop_busy", busy, 1'b0);
  endtask

  initial begin
    int lat, t, rises;
    bit held, prev, ok;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t, rises;
    bit held, prev, ok;
    reset = 1'b1; motor = 1'b0; play = 1'b0;
    byte_valid = 1'b0; byte_data = 8'd0; eot = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_casdout", casdout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_byte_ready", byte_ready, 1'b0);
    chk("rst_byte_count", byte_count, 24'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Single byte 0xA5, with start latency.
    src_q = '{8'hA5};
    prime();
    play = 1'b1;
    motor = 1'b1;
    fork
      feed();
      begin
        measure_rise(lat);
        chk("start_latency", lat, START_LAT);
      end
    join
    chk("a5_byte_count", byte_count, bc_model[23:0]);
    chk("eot_done", done, 1'b1);
    chk("eot_busy", busy, 1'b0);
    chk("eot_casdout", casdout, 1'b0);
    stop_play();

    // 0xFF then 0x00 back-to-back: length from first rise to done.
    src_q = '{8'hFF, 8'h00};
    prime();
    play = 1'b1;
    fork
      feed();
      begin
        measure_rise(lat);
        t = 0;
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
          @(negedge clk);
          t++;
          if (done) begin
            ok = 1'b1;
            break;
          end
        end
        if (ok) chk("ff00_total", t, 8 * 2 * H1 + 1 + 8 * 2 * H0 + 1);
        else timeout("ff00_total");
      end
    join
    chk("ff00_byte_count", byte_count, bc_model[23:0]);
    stop_play();

    // Motor dropped 3 cycles into the first HIGH phase for 10 cycles.
    src_q = '{8'hFF};
    prime();
    play = 1'b1;
    fork
      feed();
      begin
        measure_rise(lat);
        repeat (3) @(posedge clk);
        #1 motor = 1'b0;
        held = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (casdout !== 1'b1) held = 1'b0;
        end
        chk("motor_off_held", held, 1'b1);
        @(posedge clk); #1;
        motor = 1'b1;
        @(negedge clk);
        chk("resume_last_high", casdout, 1'b1);
        @(negedge clk);
        chk("resume_phase_end", casdout, 1'b0);
      end
    join
    chk("motor_byte_count", byte_count, bc_model[23:0]);
    stop_play();

    // Random bytes and random motor gating.
    rnd_motor = 1'b1;
    fork
      begin
        for (int s = 0; s < 6; s++) begin
          int n;
          n = $urandom_range(1, 4);
          src_q.delete();
          for (int i = 0; i < n; i++) src_q.push_back(8'($urandom_range(0, 255)));
          prime();
          play = 1'b1;
          feed();
          chk("rnd_byte_count", byte_count, bc_model[23:0]);
          stop_play();
        end
        rnd_motor = 1'b0;
      end
      begin
        while (rnd_motor) begin
          @(posedge clk); #1;
          motor = ($urandom_range(0, 3) != 0);
        end
        motor = 1'b1;
      end
    join
    chk("scoreboard_drained", exp_q.size(), 0);

    // Reset in the middle of bit 3, then restart from IDLE.
    mon_en = 1'b0;
    exp_q.delete();
    src_q = '{8'hFF};
    prime();
    play = 1'b1;
    rises = 0;
    prev = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (casdout && !prev) rises++;
      prev = casdout;
      if (rises == 4) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("bit3_rise");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_casdout", casdout, 1'b0);
    chk("midreset_byte_count", byte_count, 24'd0);
    chk("midreset_busy", busy, 1'b0);
    bc_model = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    measure_rise(lat);
    chk("restart_latency", lat, START_LAT);
    chk("restart_byte_count", byte_count, 24'd1);
    @(posedge clk); #1;
    play = 1'b0;
    byte_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("play_drop_casdout", casdout, 1'b0);
    chk("play_drop_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
